// File: rtl/region_compositor_if.sv
// Bus bundle between the content blocks, the configuration master and the
// region compositor. Configuration protocol: cfg_we is a one-cycle strobe
// with no ready/back-pressure. A write whose cfg_sel names an existing source
// is taken on the edge that samples it. cfg_pending then reports that the
// shadow bank holds data not yet promoted to the active bank.
interface region_compositor_if #(
    parameter int N_SRC = 3
);
    logic [11:0]         HCNT;
    logic [10:0]         VCNT;
    logic [24*N_SRC-1:0] src_rgb;
    logic [N_SRC-1:0]    src_led;
    logic                cfg_we;
    logic [2:0]          cfg_sel;
    logic [11:0]         cfg_hstart;
    logic [11:0]         cfg_hend;
    logic                cfg_key_en;
    logic                cfg_pending;
    logic [7:0]          R;
    logic [7:0]          G;
    logic [7:0]          B;
    logic                led;

    modport master (
        output HCNT, VCNT, src_rgb, src_led,
        output cfg_we, cfg_sel, cfg_hstart, cfg_hend, cfg_key_en,
        input  cfg_pending, R, G, B, led
    );

    modport slave (
        input  HCNT, VCNT, src_rgb, src_led,
        input  cfg_we, cfg_sel, cfg_hstart, cfg_hend, cfg_key_en,
        output cfg_pending, R, G, B, led
    );
endinterface

// File: rtl/region_compositor.sv
// Region compositor: N_SRC sources, each with a programmable horizontal
// window and an optional colour key, merged by fixed priority (index 0 wins)
// into one registered RGB/LED stream. Windows are double-buffered and are
// promoted from shadow to active at frame start (HCNT==0 && VCNT==0).
// Two-stage pipeline: hit detection, then priority select.
module region_compositor #(
    parameter int          N_SRC     = 3,
    parameter int          H_MAX     = 1680,
    parameter logic [23:0] KEY_COLOR = 24'h000000,
    parameter logic [23:0] BG_COLOR  = 24'h000000
) (
    input logic               iCLK,
    input logic               reset,
    region_compositor_if.slave bus
);

    function automatic logic [11:0] def_start(input int i);
        return 12'((i * H_MAX) / N_SRC);
    endfunction

    logic [11:0] sh_hstart  [N_SRC];
    logic [11:0] sh_hend    [N_SRC];
    logic        sh_key     [N_SRC];
    logic [11:0] act_hstart [N_SRC];
    logic [11:0] act_hend   [N_SRC];
    logic        act_key    [N_SRC];

    logic                frame_start;
    logic                cfg_accept;
    logic [N_SRC-1:0]    hit_c;

    logic [N_SRC-1:0]    s1_hit;
    logic [24*N_SRC-1:0] s1_rgb;
    logic [N_SRC-1:0]    s1_led;
    logic                s1_valid;

    logic                win_any;
    logic [23:0]         win_rgb;
    logic                win_led;

    assign frame_start = (bus.HCNT == 12'd0) && (bus.VCNT == 11'd0);
    assign cfg_accept  = bus.cfg_we && ({1'b0, bus.cfg_sel} < 4'(N_SRC));

    // Shadow/active window banks and the pending flag; the active bank takes
    // the pre-write shadow contents at frame start.
    always_ff @(posedge iCLK) begin
        if (reset) begin
            for (int i = 0; i < N_SRC; i++) begin
                sh_hstart[i]  <= def_start(i);
                sh_hend[i]    <= def_start(i + 1);
                sh_key[i]     <= 1'b0;
                act_hstart[i] <= def_start(i);
                act_hend[i]   <= def_start(i + 1);
                act_key[i]    <= 1'b0;
            end
            bus.cfg_pending <= 1'b0;
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                if (frame_start) begin
                    act_hstart[i] <= sh_hstart[i];
                    act_hend[i]   <= sh_hend[i];
                    act_key[i]    <= sh_key[i];
                end
                if (cfg_accept && (bus.cfg_sel == 3'(i))) begin
                    sh_hstart[i] <= bus.cfg_hstart;
                    sh_hend[i]   <= bus.cfg_hend;
                    sh_key[i]    <= bus.cfg_key_en;
                end
            end
            if (cfg_accept) begin
                bus.cfg_pending <= 1'b1;
            end else if (frame_start) begin
                bus.cfg_pending <= 1'b0;
            end
        end
    end

    // Per-source hit test. On the frame-start pixel the bank being promoted
    // on this edge (the shadow) is used, so that pixel already sees the new
    // windows.
    always_comb begin
        hit_c = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (frame_start) begin
                hit_c[i] = (bus.HCNT >= sh_hstart[i]) && (bus.HCNT < sh_hend[i])
                           && !(sh_key[i] && (bus.src_rgb[24*i +: 24] == KEY_COLOR));
            end else begin
                hit_c[i] = (bus.HCNT >= act_hstart[i]) && (bus.HCNT < act_hend[i])
                           && !(act_key[i] && (bus.src_rgb[24*i +: 24] == KEY_COLOR));
            end
        end
    end

    // Stage 1: register hit vector, source pixels and LEDs.
    always_ff @(posedge iCLK) begin
        if (reset) begin
            s1_hit   <= '0;
            s1_rgb   <= '0;
            s1_led   <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_hit   <= hit_c;
            s1_rgb   <= bus.src_rgb;
            s1_led   <= bus.src_led;
            s1_valid <= 1'b1;
        end
    end

    // Priority encode: the loop runs high to low so the lowest index wins.
    always_comb begin
        win_any = 1'b0;
        win_rgb = BG_COLOR;
        win_led = 1'b0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (s1_hit[i]) begin
                win_any = 1'b1;
                win_rgb = s1_rgb[24*i +: 24];
                win_led = s1_led[i];
            end
        end
    end

    // Stage 2: register the composited pixel; led holds when nothing hits.
    always_ff @(posedge iCLK) begin
        if (reset) begin
            bus.R   <= 8'd0;
            bus.G   <= 8'd0;
            bus.B   <= 8'd0;
            bus.led <= 1'b0;
        end else if (s1_valid) begin
            {bus.R, bus.G, bus.B} <= win_rgb;
            if (win_any) begin
                bus.led <= win_led;
            end
        end
    end

endmodule
